// File: rtl/cache_line_fill_engine.sv
// -----------------------------------------------------------------------------
// cache_line_fill_engine
//
// Services misses for a direct-mapped cache. On an accepted request the engine
// optionally writes a dirty victim line back to memory one block at a time,
// then reads the missing line block by block (offset 0 first). Once every
// block has arrived, the whole line is presented on the cache's write-line
// port for exactly one cycle.
//
// Ports
//   clk, rst_n           single clock, synchronous active-low reset
//   req_valid/req_ready  miss-service request handshake (ready == idle)
//   req_address          missing block address, any offset within the line
//   req_evict            victim is dirty and must be written back first
//   req_evict_address    victim line address (offset bits ignored)
//   req_evict_line       victim data, block 0 in the least significant bits
//   mem_valid/mem_ready  memory command handshake
//   mem_we               1 = write command, 0 = read command
//   mem_address          block address of the current command
//   mem_wdata            write data of the current command
//   mem_rvalid/mem_rdata read response, one outstanding read at a time
//   fill_valid           one-cycle strobe writing fill_line into the cache
//   fill_address         line base address of the fill (offset bits zero)
//   fill_line            assembled line, block 0 in the least significant bits
//   busy                 inverse of req_ready
// -----------------------------------------------------------------------------
module cache_line_fill_engine #(
    parameter int BLOCK_SIZE             = 32,
    parameter int NUM_OF_BLOCKS_PER_LINE = 4,
    parameter int ADDRESS_SIZE           = 32
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    // request side
    input  logic                                           req_valid,
    output logic                                           req_ready,
    input  logic [ADDRESS_SIZE-1:0]                        req_address,
    input  logic                                           req_evict,
    input  logic [ADDRESS_SIZE-1:0]                        req_evict_address,
    input  logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0]   req_evict_line,
    // memory side
    output logic                                           mem_valid,
    input  logic                                           mem_ready,
    output logic                                           mem_we,
    output logic [ADDRESS_SIZE-1:0]                        mem_address,
    output logic [BLOCK_SIZE-1:0]                          mem_wdata,
    input  logic                                           mem_rvalid,
    input  logic [BLOCK_SIZE-1:0]                          mem_rdata,
    // cache write-line port
    output logic                                           fill_valid,
    output logic [ADDRESS_SIZE-1:0]                        fill_address,
    output logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0]   fill_line,
    output logic                                           busy
);

    localparam int OFS    = $clog2(NUM_OF_BLOCKS_PER_LINE);
    localparam int LINE_W = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE;

    // Low address bits that select a block inside a line.
    localparam logic [ADDRESS_SIZE-1:0] OFS_MASK = ADDRESS_SIZE'(NUM_OF_BLOCKS_PER_LINE - 1);
    localparam logic [OFS-1:0]          LAST_BLK = OFS'(NUM_OF_BLOCKS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_RD,
        S_RD_WAIT,
        S_FILL
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    logic [OFS-1:0]            r_cnt;
    logic [ADDRESS_SIZE-1:0]   r_miss_base;
    logic [ADDRESS_SIZE-1:0]   r_evict_base;
    logic [LINE_W-1:0]         r_evict_line;
    logic [LINE_W-1:0]         r_line;
    logic [ADDRESS_SIZE-1:0]   r_fill_address;
    logic [LINE_W-1:0]         r_fill_line;

    logic                      w_accept;
    logic                      w_last_blk;
    logic [ADDRESS_SIZE-1:0]   w_cnt_addr;
    logic [BLOCK_SIZE-1:0]     w_evict_blk;
    logic [LINE_W-1:0]         w_line_assembled;

    assign w_accept    = req_valid & req_ready;
    assign w_last_blk  = (r_cnt == LAST_BLK);
    // Base addresses have their offset bits cleared, so OR-ing the counter in
    // is the same as adding it.
    assign w_cnt_addr  = ADDRESS_SIZE'(r_cnt);
    assign w_evict_blk = r_evict_line[int'(r_cnt) * BLOCK_SIZE +: BLOCK_SIZE];

    assign busy         = ~req_ready;
    assign fill_address = r_fill_address;
    assign fill_line    = r_fill_line;

    // Current line buffer with the arriving read block merged into its slot.
    always_comb begin
        w_line_assembled = r_line;
        w_line_assembled[int'(r_cnt) * BLOCK_SIZE +: BLOCK_SIZE] = mem_rdata;
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        mem_valid    = 1'b0;
        mem_we       = 1'b0;
        mem_address  = '0;
        mem_wdata    = '0;
        fill_valid   = 1'b0;

        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = req_evict ? S_WB : S_RD;
                end
            end

            // Write back the victim, block r_cnt; command held until accepted.
            S_WB: begin
                mem_valid   = 1'b1;
                mem_we      = 1'b1;
                mem_address = r_evict_base | w_cnt_addr;
                mem_wdata   = w_evict_blk;
                if (mem_ready && w_last_blk) begin
                    w_state_next = S_RD;
                end
            end

            // Issue the read for block r_cnt of the missing line.
            S_RD: begin
                mem_valid   = 1'b1;
                mem_address = r_miss_base | w_cnt_addr;
                if (mem_ready) begin
                    w_state_next = S_RD_WAIT;
                end
            end

            // Single outstanding read: wait for its data before the next one.
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    w_state_next = w_last_blk ? S_FILL : S_RD;
                end
            end

            S_FILL: begin
                fill_valid   = 1'b1;
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Block counter and fill output registers
    // -------------------------------------------------------------------------
    // The counter is log2(N) bits wide, so incrementing past the last block
    // wraps it to zero, ready for the read phase or the next request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_fill_address <= '0;
            r_fill_line    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                end
                S_WB: begin
                    if (mem_ready) begin
                        r_cnt <= r_cnt + OFS'(1);
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rvalid) begin
                        r_cnt <= r_cnt + OFS'(1);
                        if (w_last_blk) begin
                            r_fill_address <= r_miss_base;
                            r_fill_line    <= w_line_assembled;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Request capture and line assembly buffers
    // -------------------------------------------------------------------------
    // NOTE: these wide data buffers have no reset: each is written before it
    // is read in every service, and the controlling state above is reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_miss_base  <= req_address & ~OFS_MASK;
            r_evict_base <= req_evict_address & ~OFS_MASK;
            r_evict_line <= req_evict_line;
        end
        if ((r_state == S_RD_WAIT) && mem_rvalid) begin
            r_line <= w_line_assembled;
        end
    end

endmodule

// File: tb/tb_cache_line_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_cache_line_fill_engine
//
// Directed stimulus drives requests and a small memory model; expected memory
// commands and fills are queued when stimulus is issued, and a monitor on the
// falling edge pops and compares whenever the DUT presents a command or fill.
// -----------------------------------------------------------------------------
module tb_cache_line_fill_engine;

    localparam int BS = 32;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = N * BS;

    logic           clk;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [AW-1:0]  req_address;
    logic           req_evict;
    logic [AW-1:0]  req_evict_address;
    logic [LW-1:0]  req_evict_line;
    logic           mem_valid;
    logic           mem_ready;
    logic           mem_we;
    logic [AW-1:0]  mem_address;
    logic [BS-1:0]  mem_wdata;
    logic           mem_rvalid;
    logic [BS-1:0]  mem_rdata;
    logic           fill_valid;
    logic [AW-1:0]  fill_address;
    logic [LW-1:0]  fill_line;
    logic           busy;

    cache_line_fill_engine #(
        .BLOCK_SIZE             (BS),
        .NUM_OF_BLOCKS_PER_LINE (N),
        .ADDRESS_SIZE           (AW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_address       (req_address),
        .req_evict         (req_evict),
        .req_evict_address (req_evict_address),
        .req_evict_line    (req_evict_line),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .mem_we            (mem_we),
        .mem_address       (mem_address),
        .mem_wdata         (mem_wdata),
        .mem_rvalid        (mem_rvalid),
        .mem_rdata         (mem_rdata),
        .fill_valid        (fill_valid),
        .fill_address      (fill_address),
        .fill_line         (fill_line),
        .busy              (busy)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [BS-1:0] wdata;
    } cmd_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
        int            acc;
        int            lat;
    } fill_t;

    cmd_t          exp_cmd_q[$];
    fill_t         exp_fill_q[$];
    logic [BS-1:0] rdata_q[$];

    int   errors     = 0;
    int   checks     = 0;
    int   cyc        = 0;
    int   fills_seen = 0;
    bit   in_flight  = 0;
    int   rd_cnt     = 0;
    int   rd_delay   = 0;
    int   stall_left = 0;
    logic [AW-1:0] stall_addr = '0;

    cmd_t  mon_cmd;
    fill_t mon_fill;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Memory model: mem_ready stall injection and read responses
    // -------------------------------------------------------------------------
    always begin
        @(posedge clk);
        #1;
        if (stall_left > 0 && mem_valid && mem_we && mem_address == stall_addr) begin
            mem_ready  = 1'b0;
            stall_left = stall_left - 1;
        end else begin
            mem_ready = 1'b1;
        end
        mem_rvalid = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt = rd_cnt - 1;
            if (rd_cnt == 0 && rdata_q.size() > 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata_q.pop_front();
            end
        end
    end

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (in_flight) check("req_ready_while_busy", LW'(req_ready), LW'(1'b0));
        if (mem_valid) begin
            check("cmd_expected", LW'(exp_cmd_q.size() > 0), LW'(1'b1));
            if (exp_cmd_q.size() > 0) begin
                mon_cmd = exp_cmd_q[0];
                check("mem_we", LW'(mem_we), LW'(mon_cmd.we));
                check("mem_address", LW'(mem_address), LW'(mon_cmd.addr));
                if (mon_cmd.we) check("mem_wdata", LW'(mem_wdata), LW'(mon_cmd.wdata));
                if (mem_ready) void'(exp_cmd_q.pop_front());
            end
            if (mem_ready && !mem_we) rd_cnt = 1 + rd_delay;
        end
        if (fill_valid) begin
            check("fill_expected", LW'(exp_fill_q.size() > 0), LW'(1'b1));
            if (exp_fill_q.size() > 0) begin
                mon_fill = exp_fill_q.pop_front();
                check("fill_address", LW'(fill_address), LW'(mon_fill.addr));
                check("fill_line", fill_line, mon_fill.line);
                check("fill_cycle", LW'(cyc + 1 - mon_fill.acc), LW'(mon_fill.lat));
            end
            fills_seen++;
            in_flight = 0;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic push_writes(input logic [AW-1:0] base, input logic [LW-1:0] line);
        cmd_t c;
        for (int i = 0; i < N; i++) begin
            c.we    = 1'b1;
            c.addr  = base + AW'(i);
            c.wdata = line[i*BS +: BS];
            exp_cmd_q.push_back(c);
        end
    endtask

    task automatic push_reads(input logic [AW-1:0] base, input logic [LW-1:0] data, input int nblk);
        cmd_t c;
        for (int i = 0; i < nblk; i++) begin
            c.we    = 1'b0;
            c.addr  = base + AW'(i);
            c.wdata = '0;
            exp_cmd_q.push_back(c);
            rdata_q.push_back(data[i*BS +: BS]);
        end
    endtask

    task automatic push_fill(input logic [AW-1:0] addr, input logic [LW-1:0] line, input int acc, input int lat);
        fill_t f;
        f.addr = addr;
        f.line = line;
        f.acc  = acc;
        f.lat  = lat;
        exp_fill_q.push_back(f);
    endtask

    // Starts at #1 after a rising edge; returns #1 after the accept edge.
    task automatic do_req(input logic [AW-1:0] addr, input logic ev, input logic [AW-1:0] eaddr,
                          input logic [LW-1:0] eline, input bit hold, output int acc);
        int n;
        n = 0;
        req_address       = addr;
        req_evict         = ev;
        req_evict_address = eaddr;
        req_evict_line    = eline;
        req_valid         = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 50);
        check("req_accept", LW'(req_ready), LW'(1'b1));
        @(posedge clk);
        #1;
        acc       = cyc;
        in_flight = 1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_fill(input int target);
        int n;
        n = 0;
        while (fills_seen < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("fill_arrived", LW'(fills_seen >= target), LW'(1'b1));
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Directed tests
    // -------------------------------------------------------------------------
    logic [LW-1:0] line_a, line_b, line_d, line_c, line_e, line_f, line_g, line_h, line_k;
    int acc1, acc2, n;
    int fill_target;

    initial begin
        line_a = {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000};
        line_d = {32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001, 32'hD0D0_0000};
        line_b = {32'hB0B0_0003, 32'hB0B0_0002, 32'hB0B0_0001, 32'hB0B0_0000};
        line_e = {32'hE0E0_0003, 32'hE0E0_0002, 32'hE0E0_0001, 32'hE0E0_0000};
        line_c = {32'hC0C0_0003, 32'hC0C0_0002, 32'hC0C0_0001, 32'hC0C0_0000};
        line_f = {32'hF0F0_0003, 32'hF0F0_0002, 32'hF0F0_0001, 32'hF0F0_0000};
        line_g = {32'h6060_0003, 32'h6060_0002, 32'h6060_0001, 32'h6060_0000};
        line_h = {32'h7070_0003, 32'h7070_0002, 32'h7070_0001, 32'h7070_0000};
        line_k = {32'h8080_0003, 32'h8080_0002, 32'h8080_0001, 32'h8080_0000};
        fill_target = 0;

        rst_n             = 1'b0;
        req_valid         = 1'b0;
        req_address       = '0;
        req_evict         = 1'b0;
        req_evict_address = '0;
        req_evict_line    = '0;
        mem_ready         = 1'b1;
        mem_rvalid        = 1'b0;
        mem_rdata         = '0;

        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", LW'(req_ready), LW'(1'b1));
        check("rst_busy", LW'(busy), LW'(1'b0));
        check("rst_mem_valid", LW'(mem_valid), LW'(1'b0));
        check("rst_fill_valid", LW'(fill_valid), LW'(1'b0));
        check("rst_fill_line", fill_line, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2: clean miss at 0x106 -> reads 0x104..0x107, fill in cycle 9
        push_reads(32'h104, line_a, N);
        do_req(32'h106, 1'b0, 32'h0, '0, 1'b0, acc1);
        push_fill(32'h104, line_a, acc1, 9);
        fill_target++;
        wait_fill(fill_target);

        // 3: dirty miss, victim 0x203, request 0x10 -> fill in cycle 13
        check("fill_line_held", fill_line, line_a);
        check("fill_address_held", LW'(fill_address), LW'(32'h104));
        push_writes(32'h200, line_d);
        push_reads(32'h10, line_b, N);
        do_req(32'h10, 1'b1, 32'h203, line_d, 1'b0, acc1);
        push_fill(32'h10, line_b, acc1, 13);
        fill_target++;
        wait_fill(fill_target);

        // 4: three-cycle stall on write-back block 1 -> fill 3 cycles later
        stall_addr = 32'h201;
        stall_left = 3;
        push_writes(32'h200, line_e);
        push_reads(32'h20, line_c, N);
        do_req(32'h22, 1'b1, 32'h203, line_e, 1'b0, acc1);
        push_fill(32'h20, line_c, acc1, 16);
        fill_target++;
        wait_fill(fill_target);
        check("stall_consumed", LW'(stall_left), LW'(0));

        // 5: req_valid held high; second request accepted the cycle after FILL
        push_reads(32'h54, line_f, N);
        push_reads(32'h300, line_g, N);
        do_req(32'h55, 1'b0, 32'h0, '0, 1'b1, acc1);
        push_fill(32'h54, line_f, acc1, 9);
        req_address = 32'h300;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 60);
        check("second_req_ready", LW'(req_ready), LW'(1'b1));
        @(posedge clk);
        #1;
        acc2      = cyc;
        in_flight = 1;
        req_valid = 1'b0;
        check("second_accept_cycle", LW'(acc2 - acc1), LW'(10));
        push_fill(32'h300, line_g, acc2, 9);
        fill_target += 2;
        wait_fill(fill_target);

        // 6: reset while waiting for block 2, read data arrives after reset
        rd_delay = 1;
        push_reads(32'h40, line_h, 3);
        do_req(32'h40, 1'b0, 32'h0, '0, 1'b0, acc1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_valid && !mem_we && mem_ready && mem_address == 32'h42) && n < 50);
        check("read_blk2_issued", LW'(mem_address), LW'(32'h42));
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        in_flight = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("late_rvalid_present", LW'(mem_rvalid), LW'(1'b1));
        repeat (3) begin
            @(negedge clk);
            check("abort_req_ready", LW'(req_ready), LW'(1'b1));
            check("abort_mem_valid", LW'(mem_valid), LW'(1'b0));
        end
        check("abort_busy", LW'(busy), LW'(1'b0));
        check("abort_fill_line", fill_line, '0);
        check("abort_fill_address", LW'(fill_address), LW'(0));
        check("abort_no_fill", LW'(fills_seen), LW'(fill_target));
        @(posedge clk);
        #1;

        // Recovery: a clean miss after the abort starts again at block 0
        rd_delay = 0;
        push_reads(32'h80, line_k, N);
        do_req(32'h83, 1'b0, 32'h0, '0, 1'b0, acc1);
        push_fill(32'h80, line_k, acc1, 9);
        fill_target++;
        wait_fill(fill_target);

        repeat (3) @(posedge clk);
        check("cmd_queue_drained", LW'(exp_cmd_q.size()), LW'(0));
        check("fill_queue_drained", LW'(exp_fill_q.size()), LW'(0));
        check("fill_count", LW'(fills_seen), LW'(fill_target));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
